// File: rtl/data2signal_pkg.sv
// Shared FSM encoding and width helper for the data2signal sample consumer / DAC transmitter.
package data2signal_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StLoad,
        StShift,
        StDone
    } state_e;

    // Bits needed to count 0..value-1; never less than 1 so degenerate counters stay legal.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned res;
        res = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data2signal_sample_tick.sv
// En-gated sample period counter; tick marks the last cycle of each period.
module sample_tick
    import data2signal_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned PW = clogb2(SAMPLE_DIV);
    localparam logic [PW-1:0] PLast = PW'(SAMPLE_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q;
        if (!en_i || (pcnt_q == PLast)) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign tick_o = en_i && (pcnt_q == PLast);

endmodule

// File: rtl/data2signal.sv
// Sample requester and MSB-first serial DAC transmitter; all outputs registered.
module data2signal
    import data2signal_pkg::*;
#(
    parameter int unsigned SIZE       = 12,
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SIZE-1:0] data,
    output logic            next,
    output logic            cs_n,
    output logic            sclk,
    output logic            sdo,
    output logic            busy,
    output logic            overrun
);

    localparam int unsigned BW = clogb2(SIZE);
    localparam int unsigned SW = clogb2(SCLK_DIV) + 1;
    localparam int unsigned LW = clogb2(LATENCY);

    localparam logic [BW-1:0] BLast = BW'(SIZE - 1);
    localparam logic [SW-1:0] SHalf = SW'(SCLK_DIV);
    localparam logic [SW-1:0] SLast = SW'(2 * SCLK_DIV - 1);
    localparam logic [LW-1:0] LLast = LW'(LATENCY - 1);

    logic tick;

    state_e          state_q, state_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic [SIZE-1:0] shreg_q, shreg_d;
    logic            overrun_q, overrun_d;
    logic            next_q, next_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            sdo_q, sdo_d;
    logic            busy_q, busy_d;

    sample_tick #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (en),
        .tick_o(tick)
    );

    always_comb begin
        state_d   = state_q;
        lcnt_d    = lcnt_q;
        bcnt_d    = bcnt_q;
        scnt_d    = scnt_q;
        shreg_d   = shreg_q;
        overrun_d = overrun_q | (tick && (state_q != StIdle));

        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                lcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (lcnt_q == LLast) begin
                    state_d = StLoad;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            StLoad: begin
                shreg_d = data;
                bcnt_d  = BLast;
                scnt_d  = '0;
                state_d = StShift;
            end
            StShift: begin
                if (scnt_q == SLast) begin
                    scnt_d  = '0;
                    shreg_d = {shreg_q[SIZE-2:0], 1'b0};
                    if (bcnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        bcnt_d = bcnt_q - 1'b1;
                    end
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are derived from next-state so the registered pins line up with the state.
        next_d = (state_d == StReq);
        cs_n_d = (state_d != StShift);
        sclk_d = (state_d == StShift) && (scnt_d >= SHalf);
        sdo_d  = (state_d == StShift) ? shreg_d[SIZE-1] : 1'b0;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            lcnt_q    <= '0;
            bcnt_q    <= '0;
            scnt_q    <= '0;
            shreg_q   <= '0;
            overrun_q <= 1'b0;
            next_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            bcnt_q    <= bcnt_d;
            scnt_q    <= scnt_d;
            shreg_q   <= shreg_d;
            overrun_q <= overrun_d;
            next_q    <= next_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
        end
    end

    assign next    = next_q;
    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign sdo     = sdo_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_data2signal.sv
// Directed bench for data2signal: main instance SAMPLE_DIV=64, second instance SAMPLE_DIV=20.
module tb_data2signal;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        en2 = 1'b0;
    logic [11:0] data = '0;

    logic next, cs_n, sclk, sdo, busy, overrun;
    logic next2, cs_n2, sclk2, sdo2, busy2, overrun2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data2signal #(
        .SIZE(12), .SAMPLE_DIV(64), .SCLK_DIV(1), .LATENCY(2)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .data(data), .next(next), .cs_n(cs_n),
        .sclk(sclk), .sdo(sdo), .busy(busy), .overrun(overrun)
    );

    data2signal #(
        .SIZE(12), .SAMPLE_DIV(20), .SCLK_DIV(1), .LATENCY(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .data(data), .next(next2), .cs_n(cs_n2),
        .sclk(sclk2), .sdo(sdo2), .busy(busy2), .overrun(overrun2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        en2 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_next(output int k);
        k = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (next) begin
                k = i;
                break;
            end
        end
    endtask

    // Collects bits at sclk rising edges on the main instance, then samples DONE and IDLE.
    task automatic capture_frame(output logic [11:0] word, output int nbits,
                                 output logic cs_after, output logic busy_after,
                                 output logic busy_idle);
        logic prev;
        int   n;
        word  = '0;
        nbits = 0;
        n     = 0;
        prev  = sclk;
        while (nbits < 12 && n < 100) begin
            step();
            n++;
            if (sclk && !prev && !cs_n) begin
                word = {word[10:0], sdo};
                nbits++;
            end
            prev = sclk;
        end
        step();
        cs_after   = cs_n;
        busy_after = busy;
        step();
        busy_idle = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++; if (next !== 1'b0) begin miscompares++; $display("FAIL reset_next: got %b expected 0", next); end
        vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        vectors++; if (sdo !== 1'b0) begin miscompares++; $display("FAIL reset_sdo: got %b expected 0", sdo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst = 1'b0;
    endtask

    task automatic test_period();
        int first, last, cnt, gap_bad;
        logic ovr_seen;
        do_reset();
        en = 1'b1;
        first = -1; last = -1; cnt = 0; gap_bad = 0; ovr_seen = 1'b0;
        for (int k = 1; k <= 640; k++) begin
            step();
            if (next) begin
                if (first < 0) first = k;
                else if (k - last != 64) gap_bad++;
                last = k;
                cnt++;
            end
            if (overrun) ovr_seen = 1'b1;
        end
        vectors++; if (cnt !== 10) begin miscompares++; $display("FAIL period_count: got %0d expected 10", cnt); end
        vectors++; if (first !== 64) begin miscompares++; $display("FAIL period_first: got %0d expected 64", first); end
        vectors++; if (gap_bad !== 0) begin miscompares++; $display("FAIL period_spacing: got %0d bad gaps expected 0", gap_bad); end
        vectors++; if (ovr_seen !== 1'b0) begin miscompares++; $display("FAIL period_overrun: got %b expected 0", ovr_seen); end
        en = 1'b0;
        repeat (40) step();
    endtask

    task automatic test_shift_a5c();
        int k, nbits;
        logic [11:0] word;
        logic cs_after, busy_after, busy_idle;
        do_reset();
        data = 12'hA5C;
        en = 1'b1;
        wait_next(k);
        vectors++; if (k !== 64) begin miscompares++; $display("FAIL a5c_next_at: got %0d expected 64", k); end
        capture_frame(word, nbits, cs_after, busy_after, busy_idle);
        en = 1'b0;
        vectors++; if (nbits !== 12) begin miscompares++; $display("FAIL a5c_edges: got %0d expected 12", nbits); end
        vectors++; if (word !== 12'hA5C) begin miscompares++; $display("FAIL a5c_word: got %h expected a5c", word); end
        vectors++; if (cs_after !== 1'b1) begin miscompares++; $display("FAIL a5c_cs_done: got %b expected 1", cs_after); end
        vectors++; if (busy_after !== 1'b1) begin miscompares++; $display("FAIL a5c_busy_done: got %b expected 1", busy_after); end
        vectors++; if (busy_idle !== 1'b0) begin miscompares++; $display("FAIL a5c_busy_idle: got %b expected 0", busy_idle); end
        repeat (40) step();
    endtask

    task automatic test_load_window();
        int k, nbits;
        logic [11:0] word;
        logic cs_after, busy_after, busy_idle;
        do_reset();
        data = 12'hFFF;
        en = 1'b1;
        wait_next(k);
        repeat (3) step();
        data = 12'h123;
        step();
        data = 12'hFFF;
        capture_frame(word, nbits, cs_after, busy_after, busy_idle);
        en = 1'b0;
        vectors++; if (nbits !== 12) begin miscompares++; $display("FAIL load_edges: got %0d expected 12", nbits); end
        vectors++; if (word !== 12'h123) begin miscompares++; $display("FAIL load_word: got %h expected 123", word); end
        repeat (40) step();
    endtask

    task automatic test_overrun();
        int np, p0, p1, nb;
        logic [11:0] word;
        logic prev, ov39, ov40;
        do_reset();
        data = 12'h3C5;
        en2 = 1'b1;
        np = 0; p0 = -1; p1 = -1; nb = 0; word = '0; prev = 1'b0; ov39 = 1'bx; ov40 = 1'bx;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (next2) begin
                if (np == 0) p0 = k;
                else if (np == 1) p1 = k;
                np++;
            end
            if (sclk2 && !prev && !cs_n2 && nb < 12) begin
                word = {word[10:0], sdo2};
                nb++;
            end
            prev = sclk2;
            if (k == 39) ov39 = overrun2;
            if (k == 40) ov40 = overrun2;
        end
        vectors++; if (np !== 2) begin miscompares++; $display("FAIL ovr_pulses: got %0d expected 2", np); end
        vectors++; if (p0 !== 20) begin miscompares++; $display("FAIL ovr_first_next: got %0d expected 20", p0); end
        vectors++; if (p1 !== 60) begin miscompares++; $display("FAIL ovr_second_next: got %0d expected 60", p1); end
        vectors++; if (nb !== 12) begin miscompares++; $display("FAIL ovr_edges: got %0d expected 12", nb); end
        vectors++; if (word !== 12'h3C5) begin miscompares++; $display("FAIL ovr_word: got %h expected 3c5", word); end
        vectors++; if (ov39 !== 1'b0) begin miscompares++; $display("FAIL ovr_before_tick: got %b expected 0", ov39); end
        vectors++; if (ov40 !== 1'b1) begin miscompares++; $display("FAIL ovr_after_tick: got %b expected 1", ov40); end
        en2 = 1'b0;
        repeat (40) step();
        vectors++; if (overrun2 !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b expected 1", overrun2); end
        do_reset();
        vectors++; if (overrun2 !== 1'b0) begin miscompares++; $display("FAIL ovr_cleared: got %b expected 0", overrun2); end
    endtask

    task automatic test_reset_mid_shift();
        int k, first;
        logic sclk_seen;
        do_reset();
        data = 12'hABC;
        en = 1'b1;
        wait_next(k);
        repeat (14) step();
        vectors++; if (cs_n !== 1'b0) begin miscompares++; $display("FAIL rst_mid_in_shift: got %b expected 0", cs_n); end
        rst = 1'b1;
        step();
        vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL rst_mid_cs_n: got %b expected 1", cs_n); end
        vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sclk: got %b expected 0", sclk); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        vectors++; if (sdo !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sdo: got %b expected 0", sdo); end
        rst = 1'b0;
        first = -1;
        sclk_seen = 1'b0;
        for (int j = 1; j <= 70; j++) begin
            step();
            if (next && first < 0) first = j;
            if (sclk && first < 0) sclk_seen = 1'b1;
        end
        vectors++; if (first !== 64) begin miscompares++; $display("FAIL rst_mid_next_at: got %0d expected 64", first); end
        vectors++; if (sclk_seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_sclk: got %b expected 0", sclk_seen); end
        en = 1'b0;
        repeat (40) step();
    endtask

    task automatic test_en_drop();
        int k, k2, nbits, extra;
        logic [11:0] word;
        logic cs_after, busy_after, busy_idle;
        do_reset();
        data = 12'h5A3;
        en = 1'b1;
        wait_next(k);
        en = 1'b0;
        capture_frame(word, nbits, cs_after, busy_after, busy_idle);
        vectors++; if (nbits !== 12) begin miscompares++; $display("FAIL endrop_edges: got %0d expected 12", nbits); end
        vectors++; if (word !== 12'h5A3) begin miscompares++; $display("FAIL endrop_word: got %h expected 5a3", word); end
        vectors++; if (busy_idle !== 1'b0) begin miscompares++; $display("FAIL endrop_idle: got %b expected 0", busy_idle); end
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (next) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL endrop_quiet: got %0d pulses expected 0", extra); end
        en = 1'b1;
        wait_next(k2);
        vectors++; if (k2 !== 64) begin miscompares++; $display("FAIL endrop_reenable: got %0d expected 64", k2); end
        en = 1'b0;
        repeat (40) step();
    endtask

    initial begin
        test_reset();
        test_period();
        test_shift_a5c();
        test_load_window();
        test_overrun();
        test_reset_mid_shift();
        test_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data2signal.md
# data2signal

Sample-rate consumer and serial DAC transmitter, the downstream end of the sample-generator `next`/`data` interface. On every sample period it pulses `next` to request a sample and waits a fixed read latency. It then captures `data` and shifts it MSB-first to an external SPI-style DAC on `cs_n`/`sclk`/`sdo`. It sits between the sample generator and the board's DAC pins and sets the output sample rate.

## Interface
- `SIZE`, 12: sample width in bits; equals the generator's `SIZE`.
- `SAMPLE_DIV`, 1000: clock cycles per sample period (≥ 2).
- `SCLK_DIV`, 2: clock cycles per `sclk` half-period (≥ 1).
- `LATENCY`, 2: cycles from `next` falling to `data` valid (≥ 1).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  enables sample ticks; low holds the period counter at 0.
- `data`  in  SIZE  sample from the generator.
- `next`  out  1  one-cycle sample request pulse.
- `cs_n`  out  1  DAC chip select, active-low.
- `sclk`  out  1  DAC serial clock; idles low.
- `sdo`  out  1  DAC serial data.
- `busy`  out  1  high from REQ through DONE.
- `overrun`  out  1  sticky flag: a tick arrived while busy; cleared only by `rst`.

## Operation
- Period counter `pcnt` runs 0..SAMPLE_DIV-1 while `en`=1 and wraps. `tick` is asserted when `pcnt`=SAMPLE_DIV-1 and `en`=1.
- FSM states:
  - IDLE: on `tick`, go to REQ.
  - REQ, 1 cycle: `next`=1. Go to WAIT.
  - WAIT, LATENCY cycles.
  - LOAD, 1 cycle: `shreg`<=`data`, bit counter <= SIZE-1. Go to SHIFT.
  - SHIFT: `cs_n`=0. Each bit lasts 2·SCLK_DIV cycles. `sdo`=`shreg[SIZE-1]` for the whole bit. `sclk`=0 for the first SCLK_DIV cycles and 1 for the second SCLK_DIV cycles, so the DAC samples on the `sclk` rising edge. At the end of each bit, shift left. After bit 0, go to DONE.
  - DONE, 1 cycle: `cs_n`=1, `sclk`=0. Go to IDLE.
- `busy`=1 in every state except IDLE.
- A `tick` arriving while state≠IDLE is dropped, no request is queued, and `overrun`<=1. The transfer in flight completes unchanged.
- `en` falling mid-frame: the current frame completes, `pcnt` clears to 0, and no further ticks are generated. When `en` rises, the first tick comes SAMPLE_DIV cycles later.
- `data` is sampled only in LOAD. Changes at other times have no effect.
- Exactly one `next` pulse per accepted tick; `next` is never high outside REQ.

## Timing
- Reset values: `next`=0, `cs_n`=1, `sclk`=0, `sdo`=0, `busy`=0, `overrun`=0. State=IDLE, `pcnt`=0, `shreg`=0.
- `rst` takes effect at the next rising edge from any state, including mid-SHIFT. `cs_n` returns high immediately, and no partial frame resumes.
- Tick at edge t: `next`=1 during cycle t+1, LOAD in cycle t+2+LATENCY, first SHIFT cycle t+3+LATENCY.
- Frame length F = 1 + LATENCY + 1 + 2·SCLK_DIV·SIZE + 1 cycles. Overrun-free operation requires SAMPLE_DIV ≥ F+1.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, REQ, WAIT, LOAD, SHIFT, DONE).
  - Counter widths computed with the codebase `clogb2` function: `clogb2(SAMPLE_DIV)`, `clogb2(SCLK_DIV)`, `clogb2(SIZE)`, `clogb2(LATENCY)`.
- One sub-module, `sample_tick`: the `en`-gated period counter producing `tick`. The FSM, shift register and flags stay in `data2signal`.

## Test plan
All scenarios use SIZE=12, SAMPLE_DIV=64, SCLK_DIV=1, LATENCY=2 (F=29) unless stated.
- Reset then `en`=1 for 640 cycles: exactly 10 `next` pulses, 64 cycles apart; first pulse at cycle 64 after `en` rises; `overrun` stays 0.
- `data`=12'hA5C valid from LOAD: 12 `sclk` rising edges with `cs_n`=0; `sdo` at each edge = 1,0,1,0,0,1,0,1,1,1,0,0; `cs_n` high 1 cycle after the last bit.
- `data` driven 12'hFFF except 12'h123 in the LOAD cycle only: shifted word is 12'h123.
- SAMPLE_DIV=20 (< F+1): second tick lands mid-SHIFT → `overrun`=1 and stays 1; the first frame completes intact; the next `next` follows the next tick that falls in IDLE.
- `rst` asserted at SHIFT bit 5: next edge gives `cs_n`=1, `sclk`=0, `busy`=0, `pcnt`=0; no `sclk` edges until a new tick.
- `en` dropped at REQ: frame completes (12 bits), then no `next` for 200 cycles; re-enable → `next` 64 cycles later.
